// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// data_cache_pkg : op encodings, error codes, FSM states and lane helpers
// Revision: 1.0
// ============================================================================
package data_cache_pkg;

   // Encodings are shared with the instruction decoder
   typedef enum logic [2:0] {
      RD_NONE = 3'b000,
      RD_LB   = 3'b001,
      RD_LH   = 3'b010,
      RD_LW   = 3'b011,
      RD_LBU  = 3'b100,
      RD_LHU  = 3'b101,
      RD_ILL6 = 3'b110,
      RD_ILL7 = 3'b111
   } rd_op_e;

   typedef enum logic [1:0] {
      WR_NONE = 2'b00,
      WR_SB   = 2'b01,
      WR_SH   = 2'b10,
      WR_SW   = 2'b11
   } wr_op_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_ILLEGAL  = 2'b10,
      ERR_TIMEOUT  = 2'b11
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQUEST = 2'b01,
      ST_RESPOND = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      SZ_NONE = 2'b00,
      SZ_BYTE = 2'b01,
      SZ_HALF = 2'b10,
      SZ_WORD = 2'b11
   } size_e;

   function automatic size_e op_size(input rd_op_e rd, input wr_op_e wr);
      size_e sz;
      sz = SZ_NONE;
      case (rd)
         RD_LB, RD_LBU: sz = SZ_BYTE;
         RD_LH, RD_LHU: sz = SZ_HALF;
         RD_LW:         sz = SZ_WORD;
         default:       sz = SZ_NONE;
      endcase
      case (wr)
         WR_SB:   sz = SZ_BYTE;
         WR_SH:   sz = SZ_HALF;
         WR_SW:   sz = SZ_WORD;
         default: ;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
      logic [3:0] m;
      case (sz)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_data(input wr_op_e wr, input logic [31:0] d);
      logic [31:0] r;
      case (wr)
         WR_SB:   r = {4{d[7:0]}};
         WR_SH:   r = {2{d[15:0]}};
         WR_SW:   r = d;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_data_aligner.sv
`default_nettype none
// ============================================================================
// load_data_aligner : selects the load lane from a memory word and extends it
// Revision: 1.0
// ============================================================================
module load_data_aligner
   import data_cache_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  rd_op_e      op,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (op)
         RD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         RD_LBU:  result = {24'h0, byte_sel};
         RD_LH:   result = {{16{half_sel[15]}}, half_sel};
         RD_LHU:  result = {16'h0, half_sel};
         RD_LW:   result = word;
         default: result = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// data_cache_controller : single-outstanding load/store bridge to word memory
// Revision: 1.0
// ============================================================================
module data_cache_controller
   import data_cache_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [2:0]  DATA_CACHE_READ,
   input  logic [1:0]  DATA_CACHE_WRITE,
   input  logic [31:0] ADDRESS,
   input  logic [31:0] WRITE_DATA,
   output logic        STALL,
   output logic        RESULT_VALID,
   output logic [31:0] RESULT_DATA,
   output logic [1:0]  ERR,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic [3:0]  MEM_BYTE_EN,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q, state_d;
   rd_op_e            rd_op_q, rd_op_d;
   wr_op_e            wr_op_q, wr_op_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   err_e              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   rd_op_e            req_rd;
   wr_op_e            req_wr;
   size_e             req_size;
   logic              req_illegal;
   logic              req_misaligned;
   logic              accept;
   logic [31:0]       load_result;

   load_data_aligner u_aligner (
      .word   (MEM_RDATA),
      .offset (addr_q[1:0]),
      .op     (rd_op_q),
      .result (load_result)
   );

   always_comb begin
      req_rd         = rd_op_e'(DATA_CACHE_READ);
      req_wr         = wr_op_e'(DATA_CACHE_WRITE);
      req_size       = op_size(req_rd, req_wr);
      req_illegal    = (req_rd == RD_ILL6) || (req_rd == RD_ILL7) ||
                       ((req_rd != RD_NONE) && (req_wr != WR_NONE));
      req_misaligned = ((req_size == SZ_HALF) && ADDRESS[0]) ||
                       ((req_size == SZ_WORD) && (ADDRESS[1:0] != 2'b00));
      // Gated by RST_N so STALL is low while reset is asserted
      accept         = RST_N && REQ_VALID && (state_q == ST_IDLE) &&
                       ((req_rd != RD_NONE) || (req_wr != WR_NONE));
   end

   always_comb begin
      state_d = state_q;
      rd_op_d = rd_op_q;
      wr_op_d = wr_op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_op_d = req_rd;
               wr_op_d = req_wr;
               addr_d  = ADDRESS;
               wdata_d = WRITE_DATA;
               cnt_d   = '0;
               if (req_illegal) begin
                  state_d = ST_RESPOND;
                  err_d   = ERR_ILLEGAL;
                  rdata_d = 32'h0;
               end else if (req_misaligned) begin
                  state_d = ST_RESPOND;
                  err_d   = ERR_MISALIGN;
                  rdata_d = 32'h0;
               end else begin
                  state_d = ST_REQUEST;
               end
            end
         end
         ST_REQUEST: begin
            // An acknowledge in the final counted cycle beats the timeout
            if (MEM_ACK) begin
               state_d = ST_RESPOND;
               err_d   = ERR_OK;
               rdata_d = (wr_op_q == WR_NONE) ? load_result : 32'h0;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_RESPOND;
               err_d   = ERR_TIMEOUT;
               rdata_d = 32'h0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         rd_op_q <= RD_NONE;
         wr_op_q <= WR_NONE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         cnt_q   <= '0;
         err_q   <= ERR_OK;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         rd_op_q <= rd_op_d;
         wr_op_q <= wr_op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory-side outputs derive only from registers written at accept, so
   // they stay stable for the whole REQUEST phase
   assign REQ_READY    = (state_q == ST_IDLE);
   assign STALL        = accept || (state_q == ST_REQUEST);
   assign RESULT_VALID = (state_q == ST_RESPOND);
   assign RESULT_DATA  = rdata_q;
   assign ERR          = err_q;
   assign MEM_REQ      = (state_q == ST_REQUEST);
   assign MEM_WE       = (wr_op_q != WR_NONE);
   assign MEM_ADDR     = {addr_q[31:2], 2'b00};
   assign MEM_WDATA    = store_data(wr_op_q, wdata_q);
   assign MEM_BYTE_EN  = lane_mask(op_size(rd_op_q, wr_op_q), addr_q[1:0]);

endmodule
`default_nettype wire

// File: tb/tb_data_cache_controller.sv
`default_nettype none
// ============================================================================
// tb_data_cache_controller : directed + randomized check against a reference model
// Revision: 1.0
// ============================================================================
module tb_data_cache_controller;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        REQ_VALID = 1'b0;
   logic        REQ_READY;
   logic [2:0]  DATA_CACHE_READ = 3'b000;
   logic [1:0]  DATA_CACHE_WRITE = 2'b00;
   logic [31:0] ADDRESS = 32'h0;
   logic [31:0] WRITE_DATA = 32'h0;
   logic        STALL;
   logic        RESULT_VALID;
   logic [31:0] RESULT_DATA;
   logic [1:0]  ERR;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic [3:0]  MEM_BYTE_EN;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_RDATA = 32'h0;

   int n_total = 0;
   int n_bad   = 0;

   always #5 CLK = ~CLK;

   data_cache_controller #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .REQ_VALID        (REQ_VALID),
      .REQ_READY        (REQ_READY),
      .DATA_CACHE_READ  (DATA_CACHE_READ),
      .DATA_CACHE_WRITE (DATA_CACHE_WRITE),
      .ADDRESS          (ADDRESS),
      .WRITE_DATA       (WRITE_DATA),
      .STALL            (STALL),
      .RESULT_VALID     (RESULT_VALID),
      .RESULT_DATA      (RESULT_DATA),
      .ERR              (ERR),
      .MEM_REQ          (MEM_REQ),
      .MEM_WE           (MEM_WE),
      .MEM_ADDR         (MEM_ADDR),
      .MEM_WDATA        (MEM_WDATA),
      .MEM_BYTE_EN      (MEM_BYTE_EN),
      .MEM_ACK          (MEM_ACK),
      .MEM_RDATA        (MEM_RDATA)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference behaviour from the op rules, using plain arithmetic
   task automatic ref_txn(input int rd, input int wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          output int err, output logic [3:0] be,
                          output logic [31:0] mwd, output logic [31:0] res);
      int sz;
      int off;
      logic [31:0] mask;
      logic [31:0] lane;
      sz  = (rd == 1 || rd == 4 || wr == 1) ? 1 :
            (rd == 2 || rd == 5 || wr == 2) ? 2 : 4;
      off = int'(addr % 4);
      if (rd >= 6 || (rd != 0 && wr != 0)) err = 2;
      else if (off % sz != 0)               err = 1;
      else                                  err = 0;
      be = 4'(((1 << sz) - 1) << off);
      case (wr)
         1:       mwd = {24'h0, wdata[7:0]} * 32'h01010101;
         2:       mwd = {16'h0, wdata[15:0]} * 32'h00010001;
         3:       mwd = wdata;
         default: mwd = 32'h0;
      endcase
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      lane = (rdata >> (8 * off)) & mask;
      if ((rd == 1 || rd == 2) && lane[8 * sz - 1]) lane = lane | ~mask;
      res = (err != 0 || wr != 0) ? 32'h0 : lane;
   endtask

   // ack_at = cycle (1-based in REQUEST) carrying MEM_ACK; 0 = never
   task automatic run_txn(input int rd, input int wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ack_at);
      int err;
      logic [3:0] be;
      logic [31:0] mwd;
      logic [31:0] res;
      int j;
      bit done;
      ref_txn(rd, wr, addr, wdata, rdata, err, be, mwd, res);

      @(negedge CLK);
      REQ_VALID        = 1'b1;
      DATA_CACHE_READ  = 3'(rd);
      DATA_CACHE_WRITE = 2'(wr);
      ADDRESS          = addr;
      WRITE_DATA       = wdata;
      #1;
      check_eq("accept_ready", 32'(REQ_READY), 32'd1);
      check_eq("accept_stall", 32'(STALL), 32'd1);

      @(negedge CLK);
      REQ_VALID        = 1'b0;
      DATA_CACHE_READ  = 3'b000;
      DATA_CACHE_WRITE = 2'b00;
      ADDRESS          = $urandom;
      WRITE_DATA       = $urandom;
      if (err == 0) begin
         done = 1'b0;
         j    = 1;
         while (!done) begin
            #1;
            check_eq("req_memreq", 32'(MEM_REQ), 32'd1);
            check_eq("req_we", 32'(MEM_WE), 32'(wr != 0));
            check_eq("req_addr", MEM_ADDR, addr & 32'hFFFF_FFFC);
            check_eq("req_be", 32'(MEM_BYTE_EN), 32'(be));
            if (wr != 0) check_eq("req_wdata", MEM_WDATA, mwd);
            check_eq("req_stall", 32'(STALL), 32'd1);
            check_eq("req_rv", 32'(RESULT_VALID), 32'd0);
            if (j == ack_at) begin
               MEM_ACK   = 1'b1;
               MEM_RDATA = rdata;
               done      = 1'b1;
            end else begin
               MEM_ACK   = 1'b0;
               MEM_RDATA = $urandom;
               if (j == TMO) begin
                  done = 1'b1;
                  err  = 3;
                  res  = 32'h0;
               end
            end
            j++;
            @(negedge CLK);
         end
         MEM_ACK   = 1'($urandom_range(0, 1));
         MEM_RDATA = $urandom;
      end
      #1;
      check_eq("rsp_rv", 32'(RESULT_VALID), 32'd1);
      check_eq("rsp_err", 32'(ERR), 32'(err));
      check_eq("rsp_data", RESULT_DATA, res);
      check_eq("rsp_memreq", 32'(MEM_REQ), 32'd0);
      check_eq("rsp_stall", 32'(STALL), 32'd0);

      @(negedge CLK);
      MEM_ACK = 1'b0;
      #1;
      check_eq("idle_rv", 32'(RESULT_VALID), 32'd0);
      check_eq("idle_ready", 32'(REQ_READY), 32'd1);
      check_eq("hold_err", 32'(ERR), 32'(err));
      check_eq("hold_data", RESULT_DATA, res);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_memreq"}, 32'(MEM_REQ), 32'd0);
      check_eq({tag, "_we"}, 32'(MEM_WE), 32'd0);
      check_eq({tag, "_rv"}, 32'(RESULT_VALID), 32'd0);
      check_eq({tag, "_stall"}, 32'(STALL), 32'd0);
      check_eq({tag, "_be"}, 32'(MEM_BYTE_EN), 32'd0);
      check_eq({tag, "_err"}, 32'(ERR), 32'd0);
      check_eq({tag, "_data"}, RESULT_DATA, 32'd0);
      check_eq({tag, "_addr"}, MEM_ADDR, 32'd0);
      check_eq({tag, "_wdata"}, MEM_WDATA, 32'd0);
      check_eq({tag, "_ready"}, 32'(REQ_READY), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd;
      int wr;
      int ack;
      logic [31:0] a;

      // Reset state, with a request pending so STALL gating is exercised
      REQ_VALID       = 1'b1;
      DATA_CACHE_READ = 3'b011;
      #2;
      check_reset_outputs("reset");
      REQ_VALID       = 1'b0;
      DATA_CACHE_READ = 3'b000;
      @(negedge CLK);
      RST_N = 1'b1;

      // LW at 0x100, ack in the third REQUEST cycle
      run_txn(3, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
      check_eq("lw_const", RESULT_DATA, 32'hDEADBEEF);
      // LB / LBU at 0x103
      run_txn(1, 0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      check_eq("lb_const", RESULT_DATA, 32'hFFFFFF80);
      run_txn(4, 0, 32'h103, 32'h0, 32'h80FFFFFF, 2);
      check_eq("lbu_const", RESULT_DATA, 32'h00000080);
      // SH at 0x202
      run_txn(0, 2, 32'h202, 32'h1234ABCD, 32'h0, 1);
      // Misaligned, then illegal read code
      run_txn(3, 0, 32'h101, 32'h0, 32'h0, 1);
      check_eq("misalign_const", 32'(ERR), 32'd1);
      run_txn(6, 0, 32'h100, 32'h0, 32'h0, 1);
      check_eq("illegal_const", 32'(ERR), 32'd2);
      run_txn(1, 1, 32'h100, 32'h0, 32'h0, 1);
      // Timeout, and ack on the final counted cycle
      run_txn(3, 0, 32'h300, 32'h0, 32'h0, 0);
      check_eq("timeout_const", 32'(ERR), 32'd3);
      run_txn(3, 0, 32'h300, 32'h0, 32'hCAFEF00D, TMO);
      check_eq("ack_at_tmo_const", 32'(ERR), 32'd0);

      // REQ_VALID with no op and a stray ack are both ignored
      @(negedge CLK);
      REQ_VALID = 1'b1;
      MEM_ACK   = 1'b1;
      #1;
      check_eq("noop_stall", 32'(STALL), 32'd0);
      @(negedge CLK);
      REQ_VALID = 1'b0;
      MEM_ACK   = 1'b0;
      #1;
      check_eq("noop_ready", 32'(REQ_READY), 32'd1);
      check_eq("noop_memreq", 32'(MEM_REQ), 32'd0);
      check_eq("noop_rv", 32'(RESULT_VALID), 32'd0);

      // Reset pulsed during REQUEST, late ack after release
      @(negedge CLK);
      REQ_VALID       = 1'b1;
      DATA_CACHE_READ = 3'b011;
      ADDRESS         = 32'h40;
      @(negedge CLK);
      REQ_VALID       = 1'b0;
      DATA_CACHE_READ = 3'b000;
      #1;
      check_eq("midrst_memreq_before", 32'(MEM_REQ), 32'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge CLK);
      RST_N   = 1'b1;
      MEM_ACK = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         #1;
         check_eq("late_ack_rv", 32'(RESULT_VALID), 32'd0);
         check_eq("late_ack_ready", 32'(REQ_READY), 32'd1);
         check_eq("late_ack_memreq", 32'(MEM_REQ), 32'd0);
      end
      MEM_ACK = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         rd = int'($urandom_range(0, 7));
         wr = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) == 1) wr = 0;
            else                           rd = 0;
         end
         if (rd == 0 && wr == 0) rd = 3;
         ack = int'($urandom_range(0, TMO + 2));
         a   = $urandom;
         if ($urandom_range(0, 1) == 1) a[0] = 1'b0;
         run_txn(rd, wr, a, $urandom, $urandom, ack);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
